// File: rtl/ctx_scheduler.sv
// Round-robin time-slice scheduler for the multi-context MIPS core.
// Sequences the save/restore handshake on quantum expiry or process halt.
module ctx_scheduler #(
  parameter int NPROC   = 4,
  parameter int IDW     = 2,
  parameter int QUANTUM = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            cfg_we,
  input  logic [IDW-1:0]  cfg_id,
  input  logic [31:0]     cfg_base,
  input  logic            inst_done,
  input  logic            Halt,
  input  logic            save_ack,
  input  logic            load_ack,
  output logic            save_req,
  output logic            load_req,
  output logic [IDW-1:0]  ctx,
  output logic [31:0]     Base_addr,
  output logic            quantum,
  output logic            running,
  output logic [7:0]      slice_count,
  output logic            all_halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_LOAD   = 3'd2,
    S_RUN    = 3'd3,
    S_SAVE   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [NPROC-1:0] r_valid;
  logic [NPROC-1:0] r_done;
  logic [31:0]      r_base [NPROC];
  logic             r_first;
  logic [IDW-1:0]   r_ctx;
  logic [31:0]      r_base_addr;
  logic             r_quantum;
  logic [7:0]       r_slice_count;
  logic             r_save_req;
  logic             r_load_req;
  logic             r_running;
  logic             r_all_halted;

  logic [IDW-1:0]   w_start;
  logic [IDW-1:0]   w_idx;
  logic [IDW-1:0]   w_pick;
  logic             w_found;
  logic             w_expire;

  assign ctx         = r_ctx;
  assign Base_addr   = r_base_addr;
  assign quantum     = r_quantum;
  assign slice_count = r_slice_count;
  assign save_req    = r_save_req;
  assign load_req    = r_load_req;
  assign running     = r_running;
  assign all_halted  = r_all_halted;

  assign w_expire = inst_done && (r_slice_count == 8'(QUANTUM - 1));

  // Wrapping round-robin search; the current slot is visited last.
  always_comb begin
    w_start = r_first ? '0 : (r_ctx + IDW'(1'b1));
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 0; i < NPROC; i++) begin
      w_idx = w_start + IDW'(i);
      if (!w_found && r_valid[w_idx] && !r_done[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; Halt outranks an expiring instruction.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start)     w_next = S_SELECT; else w_next = S_IDLE;
      S_SELECT: if (w_found)   w_next = S_LOAD;   else w_next = S_DONE;
      S_LOAD:   if (load_ack)  w_next = S_RUN;    else w_next = S_LOAD;
      S_RUN: begin
        if (Halt)              w_next = S_SELECT;
        else if (w_expire)     w_next = S_SAVE;
        else                   w_next = S_RUN;
      end
      S_SAVE:   if (save_ack)  w_next = S_SELECT; else w_next = S_SAVE;
      S_DONE:                  w_next = S_DONE;
      default:                 w_next = S_IDLE;
    endcase
  end

  // Slot table, current context and slice accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid       <= '0;
      r_done        <= '0;
      r_first       <= 1'b1;
      r_ctx         <= '0;
      r_base_addr   <= 32'd0;
      r_quantum     <= 1'b0;
      r_slice_count <= 8'd0;
      for (int i = 0; i < NPROC; i++) r_base[i] <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_first <= 1'b1;
          if (cfg_we) begin
            r_base[cfg_id]  <= cfg_base;
            r_valid[cfg_id] <= 1'b1;
          end
        end
        S_SELECT: begin
          if (w_found) begin
            r_ctx       <= w_pick;
            r_base_addr <= r_base[w_pick];
            r_first     <= 1'b0;
          end
        end
        S_LOAD: begin
          if (load_ack) r_slice_count <= 8'd0;
        end
        S_RUN: begin
          if (Halt) begin
            r_done[r_ctx] <= 1'b1;
            r_quantum     <= 1'b0;
          end else if (inst_done) begin
            r_slice_count <= r_slice_count + 8'd1;
            if (w_expire) r_quantum <= 1'b1;
          end
        end
        default: begin
          r_first <= r_first;
        end
      endcase
    end
  end

  // Handshake and status outputs registered from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_save_req   <= 1'b0;
      r_load_req   <= 1'b0;
      r_running    <= 1'b0;
      r_all_halted <= 1'b0;
    end else begin
      r_save_req   <= (w_next == S_SAVE);
      r_load_req   <= (w_next == S_LOAD);
      r_running    <= (w_next == S_RUN);
      r_all_halted <= (w_next == S_DONE);
    end
  end

endmodule

// File: tb/tb_ctx_scheduler.sv
// Directed and randomized bench for ctx_scheduler against a behavioural model.
module tb_ctx_scheduler;
  localparam int NPROC = 4, IDW = 2, QUANTUM = 8;
  localparam int PH_IDLE = 0, PH_SEL = 1, PH_LOAD = 2, PH_RUN = 3, PH_SAVE = 4, PH_DONE = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, start = 1'b0, cfg_we = 1'b0;
  logic [IDW-1:0] cfg_id = '0;
  logic [31:0] cfg_base = 32'd0;
  logic inst_done = 1'b0, Halt = 1'b0, save_ack = 1'b0, load_ack = 1'b0;
  logic save_req, load_req, quantum, running, all_halted;
  logic [IDW-1:0] ctx;
  logic [31:0] Base_addr;
  logic [7:0] slice_count;

  ctx_scheduler #(.NPROC(NPROC), .IDW(IDW), .QUANTUM(QUANTUM)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_id(cfg_id),
    .cfg_base(cfg_base), .inst_done(inst_done), .Halt(Halt), .save_ack(save_ack),
    .load_ack(load_ack), .save_req(save_req), .load_req(load_req), .ctx(ctx),
    .Base_addr(Base_addr), .quantum(quantum), .running(running),
    .slice_count(slice_count), .all_halted(all_halted)
  );

  int n_chk = 0, n_fail = 0;

  // reference model
  int ph = PH_IDLE;
  bit mv [NPROC];
  bit md [NPROC];
  logic [31:0] mb [NPROC];
  int mctx = 0, mcnt = 0;
  logic [31:0] maddr = 32'd0;
  bit mfirst = 1'b1, mq = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int found;
    int c;
    if (reset) begin
      ph = PH_IDLE; mctx = 0; mcnt = 0; maddr = 32'd0; mq = 1'b0; mfirst = 1'b1;
      for (int k = 0; k < NPROC; k++) begin mv[k] = 1'b0; md[k] = 1'b0; mb[k] = 32'd0; end
    end else begin
      case (ph)
        PH_IDLE: begin
          if (cfg_we) begin mb[cfg_id] = cfg_base; mv[cfg_id] = 1'b1; end
          if (start) begin ph = PH_SEL; mfirst = 1'b1; end
        end
        PH_SEL: begin
          found = -1;
          for (int k = 0; k < NPROC; k++) begin
            c = mfirst ? k : (mctx + 1 + k) % NPROC;
            if (found < 0 && mv[c] && !md[c]) found = c;
          end
          if (found >= 0) begin
            mctx = found; maddr = mb[found]; mfirst = 1'b0; ph = PH_LOAD;
          end else ph = PH_DONE;
        end
        PH_LOAD: if (load_ack) begin mcnt = 0; ph = PH_RUN; end
        PH_RUN: begin
          if (Halt) begin md[mctx] = 1'b1; mq = 1'b0; ph = PH_SEL; end
          else if (inst_done) begin
            mcnt++;
            if (mcnt == QUANTUM) begin mq = 1'b1; ph = PH_SAVE; end
          end
        end
        PH_SAVE: if (save_ack) ph = PH_SEL;
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("save_req", save_req, ph == PH_SAVE);
    chk("load_req", load_req, ph == PH_LOAD);
    chk("running", running, ph == PH_RUN);
    chk("all_halted", all_halted, ph == PH_DONE);
    chk("ctx", ctx, 32'(mctx));
    chk("Base_addr", Base_addr, maddr);
    chk("quantum", quantum, mq);
    chk("slice_count", slice_count, 32'(mcnt));
  endtask

  task automatic cfg(input int id, input logic [31:0] b);
    cfg_we = 1'b1; cfg_id = IDW'(id); cfg_base = b;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic go_run();
    load_ack = 1'b1; tick(); load_ack = 1'b0;
  endtask

  task automatic expire();
    for (int i = 0; i < QUANTUM - 1; i++) begin
      inst_done = 1'b1; tick(); inst_done = 1'b0; tick();
    end
    inst_done = 1'b1; tick(); inst_done = 1'b0;
    chk("exp_save_req", save_req, 32'd1);
    chk("exp_quantum", quantum, 32'd1);
  endtask

  task automatic do_save();
    save_ack = 1'b1; tick(); save_ack = 1'b0; tick();
  endtask

  initial begin
    // 1: configure four slots and start
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    chk("rst_ctx", ctx, 32'd0);
    chk("rst_all_halted", all_halted, 32'd0);
    cfg(0, 32'h100); cfg(1, 32'h200); cfg(2, 32'h300); cfg(3, 32'h400);
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_sel_noload", load_req, 32'd0);
    tick();
    chk("t1_load_req", load_req, 32'd1);
    chk("t1_ctx", ctx, 32'd0);
    chk("t1_base", Base_addr, 32'h100);
    tick(); tick();
    go_run();
    chk("t1_running", running, 32'd1);
    chk("t1_count", slice_count, 32'd0);
    // 2: quantum expiry moves to next slot
    expire();
    do_save();
    chk("t2_load_req", load_req, 32'd1);
    chk("t2_ctx", ctx, 32'd1);
    chk("t2_base", Base_addr, 32'h200);

    // 3: slots 0 and 2 only, wrap then halt
    reset = 1'b1; tick(); reset = 1'b0;
    cfg(0, 32'h100); cfg(2, 32'h300);
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("t3_ctx0", ctx, 32'd0);
    go_run(); expire(); do_save();
    chk("t3_ctx2", ctx, 32'd2);
    chk("t3_base2", Base_addr, 32'h300);
    go_run(); expire(); do_save();
    chk("t3_wrap_ctx", ctx, 32'd0);
    go_run();
    Halt = 1'b1; tick(); Halt = 1'b0;
    chk("t3_halt_nosave", save_req, 32'd0);
    chk("t3_halt_q", quantum, 32'd0);
    tick();
    chk("t3_halt_load", load_req, 32'd1);
    chk("t3_next_ctx", ctx, 32'd2);
    // 4: Halt with the expiring instruction, then all halted
    go_run();
    for (int i = 0; i < QUANTUM - 1; i++) begin
      inst_done = 1'b1; tick(); inst_done = 1'b0; tick();
    end
    inst_done = 1'b1; Halt = 1'b1; tick(); inst_done = 1'b0; Halt = 1'b0;
    chk("t4_nosave", save_req, 32'd0);
    chk("t4_q", quantum, 32'd0);
    tick();
    chk("t4_all_halted", all_halted, 32'd1);
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("t4_sticky", all_halted, 32'd1);

    // 5: no valid slot, then reset during SAVE
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("t5_empty_done", all_halted, 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    cfg(1, 32'h200);
    start = 1'b1; tick(); start = 1'b0; tick();
    go_run(); expire();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_rst_save", save_req, 32'd0);
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("t5_valid_cleared", all_halted, 32'd1);

    // 6: cfg_we ignored outside IDLE
    reset = 1'b1; tick(); reset = 1'b0;
    cfg(0, 32'h100); cfg(1, 32'h200);
    start = 1'b1; tick(); start = 1'b0; tick();
    go_run();
    cfg(3, 32'hABC);
    expire(); do_save();
    chk("t6_ctx1", ctx, 32'd1);
    go_run(); expire(); do_save();
    chk("t6_skip3", ctx, 32'd0);
    chk("t6_base0", Base_addr, 32'h100);

    // randomized phase
    reset = 1'b1; tick();
    for (int c = 0; c < 1500; c++) begin
      reset     = ($urandom_range(0, 149) == 0);
      start     = ($urandom_range(0, 9) == 0);
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_id    = IDW'($urandom);
      cfg_base  = $urandom;
      inst_done = $urandom_range(0, 1) == 1;
      Halt      = ($urandom_range(0, 29) == 0);
      save_ack  = ($urandom_range(0, 2) == 0);
      load_ack  = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ctx_scheduler.md
Name: ctx_scheduler

Overview:
- Round-robin time-slice scheduler for the multi-context MIPS core.
- Holds a base address per process and counts retired instructions against a quantum.
- Sequences the save/restore handshake with the core on quantum expiry or process halt.
- Drives the ctx, quantum and Base_addr values that the core and the 7-segment status display consume.

Parameters:
NPROC, 4, number of process slots (power of two, 2..16)
IDW, 2, width of process index, equals log2(NPROC)
QUANTUM, 8, retired instructions per time slice (1..255)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; leaves IDLE and begins scheduling
cfg_we  input  1  config write strobe, honoured only in IDLE
cfg_id  input  IDW  slot written by cfg_we
cfg_base  input  32  base address for slot cfg_id; the write also sets valid[cfg_id]
inst_done  input  1  one-cycle pulse per retired instruction of the running process
Halt  input  1  running process executed halt (level, sampled in RUN only)
save_ack  input  1  core finished saving context
load_ack  input  1  core finished loading context
save_req  output  1  held high in SAVE until save_ack
load_req  output  1  held high in LOAD until load_ack
ctx  output  IDW  index of current process
Base_addr  output  32  base address of current process
quantum  output  1  1 = last switch caused by quantum expiry, 0 = by halt
running  output  1  high in RUN
slice_count  output  8  instructions retired in current slice
all_halted  output  1  high in DONE

Behaviour:
- Reset values: state IDLE, valid[]=0, done[]=0, base[]=0, ctx=0, Base_addr=0, slice_count=0, quantum=0, all outputs low.
- Reset has priority over every other input in every state, including mid-handshake; save_req and load_req drop on the next edge.
- IDLE:
  - cfg_we writes base[cfg_id] and sets valid[cfg_id]; rewriting the same slot overwrites it.
  - start goes to SELECT with first=1. cfg_we together with start: the write is applied and is visible to that same SELECT.
- SELECT (exactly 1 cycle):
  - Search start index is 0 if first=1, else (ctx+1) mod NPROC.
  - Scan wraps and covers all NPROC slots, including the current one last. Pick the first slot with valid & ~done.
  - Found: ctx<=slot, Base_addr<=base[slot], first<=0, go LOAD.
  - None found: go DONE.
- LOAD:
  - load_req=1 until the cycle load_ack is sampled high.
  - Then slice_count<=0 and go RUN.
  - ack latency is unbounded; load_ack outside LOAD is ignored.
- RUN:
  - inst_done increments slice_count, 8-bit, no wrap reachable.
  - If inst_done arrives when slice_count==QUANTUM-1: quantum<=1, go SAVE. The count reaches QUANTUM on that edge.
  - Halt=1: done[ctx]<=1, quantum<=0, go SELECT directly with no save.
  - Halt and expiring inst_done in the same cycle: Halt wins.
- SAVE:
  - save_req=1 until save_ack is sampled high, then go SELECT.
  - save_ack outside SAVE is ignored.
- DONE: all_halted=1; sticky until reset; start and cfg_we are ignored.
- Single runnable process: on quantum expiry it still goes through SAVE, SELECT and LOAD and reselects itself.
- Latency:
  - Expiry to save_req: 1 cycle.
  - save_ack to load_req: 2 cycles (SELECT, then LOAD).
  - Halt to load_req: 2 cycles.

Test Plan:
1. Config slots 0..3 bases 0x100,0x200,0x300,0x400, pulse start -> SELECT 1 cycle, load_req with ctx=0, Base_addr=0x100; load_ack -> running=1, slice_count=0.
2. In RUN ctx=0, 8 inst_done pulses -> save_req rises the cycle after the 8th pulse with quantum=1; save_ack -> load_req with ctx=1, Base_addr=0x200.
3. Only slots 0 and 2 valid; ctx=2 quantum expires -> wraps to ctx=0. Halt on ctx=0 -> no save_req, quantum=0, next ctx=2.
4. Halt and the 8th inst_done in the same cycle -> done[ctx] set, no SAVE, quantum=0. Last live process halts -> all_halted=1 two cycles later and stays high through further start pulses.
5. start with no valid slots -> DONE directly. Assert reset while save_req is high -> next edge IDLE, save_req=0, valid cleared.
6. cfg_we during RUN (cfg_id=3, 0xABC) -> ignored. A later reselection skips slot 3 if it was invalid, and base[3] is unchanged.
